// File: rtl/amux_scan_sequencer_if.sv
// Control/status bundle between a scan controller and the analog-mux sequencer.
// The master drives the scan request and configuration; the slave returns the switch enables and status.
interface amux_scan_sequencer_if #(
    parameter int N_CH = 8
);
    localparam int IDX_W = $clog2(N_CH);

    logic              start;
    logic              stop;
    logic [N_CH-1:0]   chan_mask;
    logic [3:0]        gap;
    logic [7:0]        dwell;
    logic              continuous;
    logic [N_CH-1:0]   amux_en;
    logic [N_CH-1:0]   amux_en_neg;
    logic [IDX_W-1:0]  chan_idx;
    logic              sample_strobe;
    logic              busy;
    logic              done;
    logic              start_err;

    modport master (
        output start, stop, chan_mask, gap, dwell, continuous,
        input  amux_en, amux_en_neg, chan_idx, sample_strobe, busy, done, start_err
    );

    modport slave (
        input  start, stop, chan_mask, gap, dwell, continuous,
        output amux_en, amux_en_neg, chan_idx, sample_strobe, busy, done, start_err
    );
endinterface

// File: rtl/amux_scan_sequencer.sv
// Break-before-make analog mux scan sequencer: walks the latched channel mask
// with a gap (all switches open) before every dwell (one switch closed).
module amux_scan_sequencer #(
    parameter int N_CH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    amux_scan_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(N_CH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [N_CH-1:0] ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   tgt_q, tgt_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic [3:0]         gap_q, gap_d;
    logic [7:0]         dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [N_CH-1:0]    amux_en_q, amux_en_d;
    logic [N_CH-1:0]    amux_en_neg_q;
    logic [IDX_W-1:0]   chan_idx_q, chan_idx_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start_err_q, start_err_d;
    logic [PTR_W-1:0]   nxt_in_s, nxt_hi_s, nxt_lo_s;

    // Lowest set mask bit at index >= ptr; MSB of the result flags "found".
    function automatic logic [PTR_W-1:0] find_next(input logic [N_CH-1:0] m,
                                                   input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] res;
        res = {PTR_W{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && (PTR_W'(i) >= ptr)) begin
                res = {1'b1, IDX_W'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign nxt_in_s = find_next(bus.chan_mask, {PTR_W{1'b0}});
    assign nxt_hi_s = find_next(mask_q, {1'b0, tgt_q} + {{IDX_W{1'b0}}, 1'b1});
    assign nxt_lo_s = find_next(mask_q, {PTR_W{1'b0}});

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        mask_d      = mask_q;
        gap_d       = gap_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        amux_en_d   = {N_CH{1'b0}};
        chan_idx_d  = chan_idx_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        start_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (nxt_in_s[IDX_W]) begin
                        mask_d  = bus.chan_mask;
                        gap_d   = bus.gap;
                        dwell_d = bus.dwell;
                        cont_d  = bus.continuous;
                        tgt_d   = nxt_in_s[IDX_W-1:0];
                        cnt_d   = {4'd0, bus.gap};
                        state_d = GAP;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d    = DWELL;
                    cnt_d      = dwell_q;
                    amux_en_d  = ONE_HOT0 << tgt_q;
                    chan_idx_d = tgt_q;
                    strobe_d   = (dwell_q == 8'd0);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DWELL: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (cnt_q != 8'd0) begin
                    cnt_d     = cnt_q - 8'd1;
                    amux_en_d = amux_en_q;
                    strobe_d  = (cnt_q == 8'd1);
                end else if (nxt_hi_s[IDX_W]) begin
                    state_d = GAP;
                    tgt_d   = nxt_hi_s[IDX_W-1:0];
                    cnt_d   = {4'd0, gap_q};
                end else if (cont_q && nxt_lo_s[IDX_W]) begin
                    // Wrap: pointer restarts at channel 0 for the next pass.
                    state_d = GAP;
                    tgt_d   = nxt_lo_s[IDX_W-1:0];
                    cnt_d   = {4'd0, gap_q};
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, configuration and registered outputs; reset forces all switches open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            tgt_q         <= {IDX_W{1'b0}};
            mask_q        <= {N_CH{1'b0}};
            gap_q         <= 4'd0;
            dwell_q       <= 8'd0;
            cont_q        <= 1'b0;
            amux_en_q     <= {N_CH{1'b0}};
            amux_en_neg_q <= {N_CH{1'b1}};
            chan_idx_q    <= {IDX_W{1'b0}};
            strobe_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            start_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            mask_q        <= mask_d;
            gap_q         <= gap_d;
            dwell_q       <= dwell_d;
            cont_q        <= cont_d;
            amux_en_q     <= amux_en_d;
            amux_en_neg_q <= ~amux_en_d;
            chan_idx_q    <= chan_idx_d;
            strobe_q      <= strobe_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            start_err_q   <= start_err_d;
        end
    end

    assign bus.amux_en       = amux_en_q;
    assign bus.amux_en_neg   = amux_en_neg_q;
    assign bus.chan_idx      = chan_idx_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.start_err     = start_err_q;
endmodule

// File: tb/tb_amux_scan_sequencer.sv
// Directed bench for amux_scan_sequencer: hand-computed sequences checked cycle by cycle.
module tb_amux_scan_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    amux_scan_sequencer_if #(.N_CH(8)) bus ();

    amux_scan_sequencer #(.N_CH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] m, input logic [3:0] g, input logic [7:0] d, input logic c);
        bus.chan_mask  = m;
        bus.gap        = g;
        bus.dwell      = d;
        bus.continuous = c;
    endtask

    initial begin
        logic [7:0] seq1 [16];
        logic [7:0] e8;
        seq1 = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h04,
                 8'h04, 8'h04, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20, 8'h00};
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cfg(8'h00, 4'd0, 8'd0, 1'b0);

        // Reset values while rst is held.
        step(); step();
        chk("rst_en", {24'd0, bus.amux_en}, 32'h00);
        chk("rst_en_neg", {24'd0, bus.amux_en_neg}, 32'hFF);
        chk("rst_idx", {29'd0, bus.chan_idx}, 32'd0);
        chk("rst_flags", {28'd0, bus.busy, bus.done, bus.sample_strobe, bus.start_err}, 32'd0);
        rst = 1'b0;
        step();

        // Single pass, mask 0x25, gap 1, dwell 2.
        cfg(8'h25, 4'd1, 8'd2, 1'b0);
        bus.start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            bus.start = 1'b0;
            chk("p1_en", {24'd0, bus.amux_en}, {24'd0, seq1[c-1]});
            chk("p1_neg", {24'd0, bus.amux_en_neg}, {24'd0, ~seq1[c-1]});
            chk("p1_strobe", {31'd0, bus.sample_strobe}, {31'd0, (c == 5 || c == 10 || c == 15)});
            chk("p1_done", {31'd0, bus.done}, {31'd0, (c == 16)});
            chk("p1_busy", {31'd0, bus.busy}, {31'd0, (c <= 15)});
            chk("p1_idx", {29'd0, bus.chan_idx}, (c >= 13) ? 32'd5 : ((c >= 8) ? 32'd2 : 32'd0));
        end
        step();

        // Continuous wrap over mask 0x81, then stop while 0x80 is on.
        cfg(8'h81, 4'd0, 8'd0, 1'b1);
        bus.start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            bus.start = 1'b0;
            e8 = (c % 4 == 2) ? 8'h01 : ((c % 4 == 0) ? 8'h80 : 8'h00);
            chk("wrap_en", {24'd0, bus.amux_en}, {24'd0, e8});
            chk("wrap_done", {31'd0, bus.done}, 32'd0);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop_en", {24'd0, bus.amux_en}, 32'h00);
        chk("stop_neg", {24'd0, bus.amux_en_neg}, 32'hFF);
        chk("stop_busy", {31'd0, bus.busy}, 32'd0);
        chk("stop_done", {31'd0, bus.done}, 32'd0);
        chk("stop_strobe", {31'd0, bus.sample_strobe}, 32'd0);
        step();
        chk("stop_done2", {31'd0, bus.done}, 32'd0);

        // Rejected starts: empty mask, then start together with stop.
        cfg(8'h00, 4'd0, 8'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("err_pulse", {31'd0, bus.start_err}, 32'd1);
        chk("err_busy", {31'd0, bus.busy}, 32'd0);
        step();
        chk("err_clear", {31'd0, bus.start_err}, 32'd0);
        chk("err_busy2", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        chk("ss_empty_err", {31'd0, bus.start_err}, 32'd0);
        cfg(8'h01, 4'd0, 8'd0, 1'b0);
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("ss_busy", {31'd0, bus.busy}, 32'd0);
        chk("ss_err", {31'd0, bus.start_err}, 32'd0);
        step();
        chk("ss_en", {24'd0, bus.amux_en}, 32'h00);

        // Maximum counts: 16 off cycles, 256 on cycles.
        cfg(8'h80, 4'd15, 8'd255, 1'b0);
        bus.start = 1'b1;
        for (int c = 1; c <= 273; c++) begin
            step();
            bus.start = 1'b0;
            e8 = (c >= 17 && c <= 272) ? 8'h80 : 8'h00;
            chk("max_en", {24'd0, bus.amux_en}, {24'd0, e8});
            chk("max_strobe", {31'd0, bus.sample_strobe}, {31'd0, (c == 272)});
            chk("max_done", {31'd0, bus.done}, {31'd0, (c == 273)});
        end
        step();

        // Asynchronous reset in the middle of a dwell on channel 1.
        cfg(8'h06, 4'd0, 8'd5, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("ar_pre_en", {24'd0, bus.amux_en}, 32'h02);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_en", {24'd0, bus.amux_en}, 32'h00);
        chk("ar_neg", {24'd0, bus.amux_en_neg}, 32'hFF);
        chk("ar_busy", {31'd0, bus.busy}, 32'd0);
        chk("ar_idx", {29'd0, bus.chan_idx}, 32'd0);
        step();
        rst = 1'b0;
        step();
        cfg(8'h03, 4'd0, 8'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("ar_restart_en", {24'd0, bus.amux_en}, 32'h01);
        chk("ar_restart_idx", {29'd0, bus.chan_idx}, 32'd0);
        step(); step(); step();

        // Inputs changed mid-scan are ignored; mask 0x05, gap 0, dwell 1.
        cfg(8'h05, 4'd0, 8'd1, 1'b0);
        bus.start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) cfg(8'hFF, 4'd3, 8'd7, 1'b1);
            if (c == 6) bus.start = 1'b0;
            e8 = (c == 2 || c == 3) ? 8'h01 : ((c == 5 || c == 6) ? 8'h04 : 8'h00);
            chk("ign_en", {24'd0, bus.amux_en}, {24'd0, e8});
            chk("ign_done", {31'd0, bus.done}, {31'd0, (c == 7)});
            chk("ign_busy", {31'd0, bus.busy}, {31'd0, (c <= 6)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
